// File: rtl/cnt6_pkg.sv
// Shared constants, count type and wrap-aware next-count function for the
// six-phase sequencer.
`timescale 1ns/1ps
package cnt6_pkg;

  localparam int CNT6_MODULUS = 6;
  localparam int CNT6_QW      = 3;
  localparam int CNT6_SW      = 8;

  typedef logic [CNT6_QW-1:0] cnt_t;

  // Compare before increment so the sum never needs bit QW; any value at or
  // above the last legal state (including upset values 6/7) returns to 0.
  function automatic cnt_t cnt6_next(input cnt_t q, input int unsigned modulus);
    return (32'(q) >= (modulus - 32'd1)) ? '0 : q + cnt_t'(1);
  endfunction

endpackage

// File: rtl/cnt6_onehot_dec.sv
// Combinational binary-to-one-hot decoder: o_s[i] is high iff i_q == i.
`timescale 1ns/1ps
module cnt6_onehot_dec #(
  parameter int QW = 3,
  parameter int SW = 8
) (
  input  logic [QW-1:0] i_q,
  output logic [SW-1:0] o_s
);

  generate
    for (genvar gi = 0; gi < SW; gi++) begin : g_bit
      assign o_s[gi] = (i_q == QW'(gi));
    end
  endgenerate

endmodule

// File: rtl/cnt6.sv
// Free-running modulo-6 up-counter with one-hot phase strobes on S.
// Reset is asynchronous and forces Q = 0 / S = 8'h01 without a clock edge.
`timescale 1ns/1ps
module cnt6
  import cnt6_pkg::*;
#(
  parameter int MODULUS = CNT6_MODULUS,
  parameter int QW      = CNT6_QW,
  parameter int SW      = CNT6_SW
) (
  input  logic          CLK,
  input  logic          RST,
  output logic [QW-1:0] Q,
  output logic [SW-1:0] S
);

  logic [QW-1:0] r_q;
  logic [QW-1:0] w_q_next;

  assign w_q_next = cnt6_next(r_q, MODULUS);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_next;
    end
  end

  assign Q = r_q;

  cnt6_onehot_dec #(
    .QW (QW),
    .SW (SW)
  ) u_dec (
    .i_q (r_q),
    .o_s (S)
  );

endmodule

// File: tb/tb_cnt6.sv
// Self-checking bench for cnt6: randomized run lengths and reset pulses
// checked against an integer modulo-6 model.
`timescale 1ns/1ps
module tb_cnt6;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [2:0] Q;
  logic [7:0] S;

  int n_tests = 0;
  int n_fail  = 0;
  int model_q = 0;

  cnt6 dut (
    .CLK (CLK),
    .RST (RST),
    .Q   (Q),
    .S   (S)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] exp_s(input int v);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) if (k == v) r[k] = 1'b1;
    return r;
  endfunction

  task automatic test_reset();
    #6 RST = 1'b1;
    #1;
    n_tests++;
    if (Q !== 3'd0) begin n_fail++; $display("FAIL reset_q: got %0d want 0", Q); end
    n_tests++;
    if (S !== 8'h01) begin n_fail++; $display("FAIL reset_s: got %h want 01", S); end
    #4 RST = 1'b0;
    model_q = 0;
    $display("[TB] reset pulse: Q=%0d S=%h", Q, S);
  endtask

  task automatic test_count();
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK);
      model_q = (model_q + 1) % 6;
      @(negedge CLK);
      n_tests++;
      if (Q !== 3'(model_q) || S !== exp_s(model_q)) begin
        n_fail++;
        $display("FAIL count[%0d]: got Q=%0d S=%h want Q=%0d S=%h", i, Q, S, model_q, exp_s(model_q));
      end
      $display("[TB] count edge %0d: Q=%0d S=%h", i, Q, S);
    end
  endtask

  task automatic test_wrap();
    int bad = 0;
    int wraps = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK);
      if (model_q == 5) wraps++;
      model_q = (model_q + 1) % 6;
      @(negedge CLK);
      if (Q !== 3'(model_q) || S !== exp_s(model_q) || Q > 3'd5 || S[7:6] !== 2'b00) begin
        bad++;
        $display("FAIL wrap[%0d]: got Q=%0d S=%h want Q=%0d S=%h", i, Q, S, model_q, exp_s(model_q));
      end
    end
    n_tests++;
    if (bad != 0) n_fail++;
    $display("[TB] wrap run: 100 cycles, %0d wraps, %0d bad", wraps, bad);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 8 && model_q != 4; i++) begin
      @(posedge CLK);
      model_q = (model_q + 1) % 6;
      @(negedge CLK);
    end
    n_tests++;
    if (Q !== 3'd4) begin n_fail++; $display("FAIL mid_pre: got %0d want 4", Q); end
    #1 RST = 1'b1;
    #1;
    n_tests++;
    if (Q !== 3'd0 || S !== 8'h01) begin
      n_fail++; $display("FAIL mid_async: got Q=%0d S=%h want 0/01", Q, S);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      n_tests++;
      if (Q !== 3'd0) begin n_fail++; $display("FAIL mid_hold[%0d]: got %0d want 0", i, Q); end
    end
    RST = 1'b0;
    model_q = 0;
    @(posedge CLK);
    model_q = 1;
    #1;
    n_tests++;
    if (Q !== 3'd1 || S !== 8'h02) begin
      n_fail++; $display("FAIL mid_release: got Q=%0d S=%h want 1/02", Q, S);
    end
    $display("[TB] mid-count reset: Q after release edge=%0d", Q);
    @(negedge CLK);
  endtask

  task automatic test_coincident();
    for (int i = 0; i < 8 && model_q != 2; i++) begin
      @(posedge CLK);
      model_q = (model_q + 1) % 6;
      @(negedge CLK);
    end
    @(posedge CLK);
    RST = 1'b1;
    #1;
    n_tests++;
    if (Q !== 3'd0) begin n_fail++; $display("FAIL coinc_rise: got %0d want 0", Q); end
    @(negedge CLK);
    // Release lands in the same time step as the edge; the flop still sees RST high.
    @(posedge CLK);
    RST <= 1'b0;
    #1;
    n_tests++;
    if (Q !== 3'd0) begin n_fail++; $display("FAIL coinc_fall: got %0d want 0", Q); end
    @(posedge CLK);
    #1;
    model_q = 1;
    n_tests++;
    if (Q !== 3'd1) begin n_fail++; $display("FAIL coinc_next: got %0d want 1", Q); end
    $display("[TB] coincident reset edges: Q=%0d", Q);
    @(negedge CLK);
  endtask

  task automatic test_random_reset();
    for (int it = 0; it < 20; it++) begin
      int run;
      int bad;
      int hold;
      run  = int'($urandom_range(1, 14));
      bad  = 0;
      for (int i = 0; i < run; i++) begin
        @(posedge CLK);
        model_q = (model_q + 1) % 6;
        @(negedge CLK);
        if (Q !== 3'(model_q) || S !== exp_s(model_q)) bad++;
      end
      n_tests++;
      if (bad != 0) begin
        n_fail++; $display("FAIL rand_run[%0d]: %0d cycles off model (Q=%0d want %0d)", it, bad, Q, model_q);
      end
      #($urandom_range(1, 3)) RST = 1'b1;
      #1;
      model_q = 0;
      n_tests++;
      if (Q !== 3'd0 || S !== 8'h01) begin
        n_fail++; $display("FAIL rand_rst[%0d]: got Q=%0d S=%h want 0/01", it, Q, S);
      end
      hold = int'($urandom_range(0, 2));
      @(negedge CLK);
      for (int h = 0; h < hold; h++) begin
        @(negedge CLK);
      end
      RST = 1'b0;
      $display("[TB] random iter %0d: run=%0d hold=%0d Q=%0d", it, run, hold, Q);
    end
  endtask

  task automatic test_illegal();
    for (int v = 6; v < 8; v++) begin
      force dut.r_q = 3'(v);
      #1;
      n_tests++;
      if (Q !== 3'(v) || S !== exp_s(v)) begin
        n_fail++; $display("FAIL illegal_show[%0d]: got Q=%0d S=%h want %0d/%h", v, Q, S, v, exp_s(v));
      end
      release dut.r_q;
      @(posedge CLK);
      #1;
      model_q = 0;
      n_tests++;
      if (Q !== 3'd0 || S !== 8'h01) begin
        n_fail++; $display("FAIL illegal_recover[%0d]: got Q=%0d S=%h want 0/01", v, Q, S);
      end
      $display("[TB] illegal state %0d recovered to Q=%0d", v, Q);
      @(negedge CLK);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_mid_reset();
    test_coincident();
    test_random_reset();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cnt6.md
Name: cnt6

Overview:
- Free-running modulo-6 up-counter with a one-hot decoded state output.
- Q carries the binary count 0..5. S carries the same state as one-hot: bit S[Q] is set, all other bits are clear.
- Used as a six-phase sequencer/timing generator. Downstream logic taps individual S bits as phase strobes.

Parameters:
- MODULUS, 6, number of states; count runs 0..MODULUS-1 then wraps to 0.
- QW, 3, width of binary count Q; must satisfy 2**QW >= MODULUS.
- SW, 8, width of decoded output S; must satisfy SW >= MODULUS. Normally 2**QW.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset; clears the count immediately, independent of CLK.
- Q    output QW (3)  current count, binary, range 0..5.
- S    output SW (8)  one-hot decode of Q: S[i] = 1 iff Q == i.

Behaviour:
- Interface: one clock (CLK); reset RST is asynchronous and active-high.
- Reset:
  - While RST = 1: Q = 3'd0, S = 8'h01, regardless of CLK.
  - Assertion takes effect without waiting for a clock edge.
- After RST deasserts:
  - The first CLK rising edge advances Q to 1.
  - Each subsequent rising edge adds 1.
- Wrap-around: when Q = 5 (MODULUS-1), the next rising edge loads 0, not 6. Sequence is 0,1,2,3,4,5,0,1,...; period 6 clocks.
- Illegal-state recovery: if Q ever holds 6 or 7 (e.g. upset), the next rising edge loads 0.
- No enable and no load: the counter advances on every rising edge while RST = 0.
- Decode:
  - S is purely combinational from the Q register: S = 1 << Q.
  - Zero-cycle latency relative to Q; S changes in the same delta as Q.
  - Exactly one bit of S is high in every legal state.
  - S[7:6] are never asserted for legal states.
  - For an illegal Q (6/7), S shows the corresponding one-hot bit until recovery. No zero or all-ones pattern.
- Width rule: next-count computed in QW bits; the compare against MODULUS-1 happens before increment, so no overflow into bit QW.
- Simultaneous RST rising and CLK rising: reset wins; Q = 0.
- RST deasserting coincident with a CLK edge: that edge does not count. Q stays 0 and the first increment occurs on the following edge.
- Reset mid-operation (any Q value): immediate return to Q = 0, S = 8'h01. Counting restarts from 0 after release.
- Outputs are glitch-free on Q (registered). S may glitch combinationally during Q transitions. Consumers sample S on CLK.

Decomposition:
- Shared package cnt6_pkg:
  - constants CNT6_MODULUS = 6, CNT6_QW = 3, CNT6_SW = 8;
  - a count typedef (logic [CNT6_QW-1:0]);
  - a function computing the next count with wrap.
- One sub-module, cnt6_onehot_dec: pure combinational binary-to-one-hot decoder, parameterised by QW/SW, instantiated once for S.
- Counter register and next-state logic remain in cnt6.

Test Plan:
- Power-up, RST pulsed high for half a clock period with no CLK edge during the pulse -> Q = 0, S = 8'h01 immediately, before any edge.
- Release RST, apply 12 rising edges -> Q = 1,2,3,4,5,0,1,2,3,4,5,0. S = 02,04,08,10,20,01,... S[3] high only when Q = 3; S[2] only at Q = 2; S[1] only at Q = 1.
- Wrap check: at Q = 5 (S = 8'h20) one edge -> Q = 0, S = 8'h01. Q never reads 6 or 7; S[7:6] stay 0 across 100 cycles.
- Mid-count reset: at Q = 4 assert RST between edges -> Q = 0, S = 8'h01 without a clock edge. Hold RST over 3 edges -> Q stays 0. Release -> next edge Q = 1.
- Coincident events: RST rises on the same instant as a CLK rising edge at Q = 2 -> Q = 0. RST falls on a CLK edge -> Q remains 0 for that edge, becomes 1 on the next.
- Illegal-state recovery: force Q = 6 (S = 8'h40), release force -> next edge Q = 0, S = 8'h01.
